// File: rtl/arith_pkg.sv
// Shared arithmetic-unit constants: operand widths, FSM encoding and the
// iteration count used by the sequential divider.
package arith_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  // Partial remainder carries one extra bit so the trial subtract can see
  // the bit shifted out of the divisor-width window.
  localparam int REM_W      = DIVISOR_W + 1;
  localparam int ITERATIONS = 16;
  localparam int CNT_W      = 4;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/subtractor.sv
// Combinational trial-subtract stage: diff = a - b, borrow set when b > a.
module subtractor
  import arith_pkg::*;
(
  input  logic [REM_W-1:0] a,
  input  logic [REM_W-1:0] b,
  output logic [REM_W-1:0] diff,
  output logic             borrow
);

  // One extra bit on the left catches the borrow out of the subtraction.
  assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/divider.sv
// Sequential 16-by-8 unsigned restoring divider, one quotient bit per clock.
// The dividend register doubles as the quotient register: each iteration
// shifts one dividend bit out of the top and one quotient bit in at the
// bottom. Q and R are only written when a result is complete.
module divider
  import arith_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic [DIVIDEND_W-1:0] X,
  input  logic [DIVISOR_W-1:0]  Y,
  output logic [DIVIDEND_W-1:0] Q,
  output logic [DIVISOR_W-1:0]  R,
  output logic                  Busy,
  output logic                  Done,
  output logic                  DivZero
);

  state_e                state_q,   state_d;
  logic [DIVIDEND_W-1:0] dvd_q,     dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q,     dvs_d;
  logic [REM_W-1:0]      rem_q,     rem_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [DIVIDEND_W-1:0] q_q,       q_d;
  logic [DIVISOR_W-1:0]  r_q,       r_d;
  logic                  done_q,    done_d;
  logic                  divzero_q, divzero_d;

  logic [REM_W-1:0]      trial;
  logic [REM_W-1:0]      diff;
  logic                  borrow;
  logic                  qbit;
  logic [DIVIDEND_W-1:0] dvd_shifted;

  // Bring down the next dividend bit next to the partial remainder.
  assign trial = {rem_q[DIVISOR_W-1:0], dvd_q[DIVIDEND_W-1]};

  subtractor u_subtractor (
    .a      (trial),
    .b      ({1'b0, dvs_q}),
    .diff   (diff),
    .borrow (borrow)
  );

  assign qbit        = ~borrow;
  assign dvd_shifted = {dvd_q[DIVIDEND_W-2:0], qbit};

  // Next-state, datapath iteration and result capture.
  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path through
    // the case statement leaves one unassigned (that would infer a latch).
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    r_d       = r_q;
    done_d    = 1'b0;
    divzero_d = divzero_q;

    case (state_q)
      ST_CALC: begin
        // Restore on borrow by keeping the trial value unchanged.
        rem_d = borrow ? trial : diff;
        dvd_d = dvd_shifted;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          q_d     = dvd_shifted;
          r_d     = rem_d[DIVISOR_W-1:0];
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      // IDLE, and the unused 2'b11 code which behaves as IDLE.
      default: begin
        state_d = ST_IDLE;
        if (Start) begin
          if (Y != '0) begin
            dvd_d     = X;
            dvs_d     = Y;
            rem_d     = '0;
            cnt_d     = '0;
            divzero_d = 1'b0;
            state_d   = ST_CALC;
          end else begin
            q_d       = '1;
            r_d       = '1;
            divzero_d = 1'b1;
            done_d    = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge Clk or negedge Rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; all registers, including the internal
    // shift registers, are cleared so an aborted division leaves no residue.
    if (!Rst) begin
      state_q   <= ST_IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      q_q       <= '0;
      r_q       <= '0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      r_q       <= r_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  assign Q       = q_q;
  assign R       = r_q;
  assign Done    = done_q;
  assign DivZero = divzero_q;
  assign Busy    = (state_q == ST_CALC) || (state_q == ST_DONE);

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for the sequential divider: a cycle-level reference
// model built from plain division and a busy-cycle countdown, compared on
// every falling edge, plus directed vectors with literal expectations.
module tb_divider;

  logic        Clk   = 1'b0;
  logic        Rst   = 1'b0;
  logic        Start = 1'b0;
  logic [15:0] X     = '0;
  logic [7:0]  Y     = '0;
  logic [15:0] Q;
  logic [7:0]  R;
  logic        Busy;
  logic        Done;
  logic        DivZero;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;

  divider dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Start   (Start),
    .X       (X),
    .Y       (Y),
    .Q       (Q),
    .R       (R),
    .Busy    (Busy),
    .Done    (Done),
    .DivZero (DivZero)
  );

  always #5 Clk = ~Clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a division occupies the unit for 17 edges after the
  // accepting edge (16 iterations plus the Done cycle); a zero divisor
  // occupies it for one edge. Results come from the arithmetic operators.
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic        m_dz   = 1'b0;
  logic [15:0] m_q    = '0;
  logic [7:0]  m_r    = '0;
  logic [15:0] p_q    = '0;
  logic [7:0]  p_r    = '0;

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_dz   = 1'b0;
      m_q    = '0;
      m_r    = '0;
    end else if (m_left == 0) begin
      m_done = 1'b0;
      if (Start) begin
        if (Y == 8'd0) begin
          m_q    = 16'hFFFF;
          m_r    = 8'hFF;
          m_dz   = 1'b1;
          m_done = 1'b1;
          m_left = 1;
        end else begin
          p_q    = X / {8'd0, Y};
          p_r    = 8'(X % {8'd0, Y});
          m_dz   = 1'b0;
          m_left = 17;
        end
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 1) begin
        m_done = 1'b1;
        m_q    = p_q;
        m_r    = p_r;
      end else begin
        m_done = 1'b0;
      end
    end
  end

  // Compare process: every falling edge outside reset.
  always @(negedge Clk) begin
    if (Rst) begin
      check("cyc_busy",    32'(Busy),    32'(m_left != 0));
      check("cyc_done",    32'(Done),    32'(m_done));
      check("cyc_divzero", 32'(DivZero), 32'(m_dz));
      check("cyc_q",       32'(Q),       32'(m_q));
      check("cyc_r",       32'(R),       32'(m_r));
    end
  end

  always @(negedge Clk) begin
    if (Done) n_done++;
  end

  // One pulsed-Start division with literal expectations on result,
  // Done latency after the accepting edge and number of busy cycles.
  task automatic run_div(input logic [15:0] x, input logic [7:0] y,
                         input logic [15:0] eq, input logic [7:0] er,
                         input logic edz, input int elat, input int ebusy,
                         input string tag);
    int  lat;
    int  busy;
    bit  seen;
    bit  finished;
    lat = -1; busy = 0; seen = 0; finished = 0;
    @(posedge Clk); #1;
    X = x; Y = y; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge Clk);
      if (Done && !seen) begin
        seen = 1;
        lat  = c;
      end
      if (Busy) busy++;
      else begin
        finished = 1;
        break;
      end
      @(posedge Clk);
    end
    check({tag, "_finished"}, 32'(finished), 32'd1);
    check({tag, "_latency"},  32'(lat),      32'(elat));
    check({tag, "_busy_cyc"}, 32'(busy),     32'(ebusy));
    check({tag, "_q"},        32'(Q),        32'(eq));
    check({tag, "_r"},        32'(R),        32'(er));
    check({tag, "_divzero"},  32'(DivZero),  32'(edz));
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit got;
    got = 0;
    for (int c = 0; c < budget; c++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (Done) begin
        got = 1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
  endtask

  initial begin
    int base;
    logic [15:0] rx;
    logic [7:0]  ry;

    // Reset state.
    repeat (3) @(posedge Clk);
    #1;
    check("rst_q",       32'(Q),       32'd0);
    check("rst_r",       32'(R),       32'd0);
    check("rst_busy",    32'(Busy),    32'd0);
    check("rst_done",    32'(Done),    32'd0);
    check("rst_divzero", 32'(DivZero), 32'd0);
    Rst = 1'b1;

    // Directed vectors.
    run_div(16'd100,   8'd7,   16'd14,     8'd2,   1'b0, 16, 17, "d100_7");
    run_div(16'd65535, 8'd255, 16'd257,    8'd0,   1'b0, 16, 17, "d65535_255");
    run_div(16'd5,     8'd10,  16'd0,      8'd5,   1'b0, 16, 17, "d5_10");
    run_div(16'd1234,  8'd0,   16'hFFFF,   8'hFF,  1'b1, 0,  1,  "dz1234");
    run_div(16'd0,     8'd1,   16'd0,      8'd0,   1'b0, 16, 17, "d0_1");
    run_div(16'd65535, 8'd1,   16'd65535,  8'd0,   1'b0, 16, 17, "d65535_1");
    run_div(16'd100,   8'd7,   16'd14,     8'd2,   1'b0, 16, 17, "d100_7b");

    // Asynchronous reset between edges, five edges into a division.
    @(posedge Clk); #1;
    X = 16'd1000; Y = 8'd7; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (5) @(posedge Clk);
    #3;
    Rst = 1'b0;
    #1;
    check("abort_q",       32'(Q),       32'd0);
    check("abort_r",       32'(R),       32'd0);
    check("abort_busy",    32'(Busy),    32'd0);
    check("abort_done",    32'(Done),    32'd0);
    check("abort_divzero", 32'(DivZero), 32'd0);
    base = n_done;
    repeat (2) @(posedge Clk);
    #2;
    Rst = 1'b1;
    repeat (25) @(posedge Clk);
    #1;
    check("abort_no_done", 32'(n_done - base), 32'd0);
    check("abort_idle",    32'(Busy),          32'd0);
    run_div(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 16, 17, "after_abort");

    // Start held high; operands change during CALC and must not matter.
    @(posedge Clk); #1;
    X = 16'd200; Y = 8'd3; Start = 1'b1;
    @(posedge Clk);
    repeat (3) @(posedge Clk);
    #1;
    X = 16'd9; Y = 8'd9;
    wait_done(40, "held1");
    check("held1_q", 32'(Q), 32'd66);
    check("held1_r", 32'(R), 32'd2);
    wait_done(60, "held2");
    check("held2_q", 32'(Q), 32'd1);
    check("held2_r", 32'(R), 32'd0);
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (!Busy) break;
    end
    check("held_idle", 32'(Busy), 32'd0);

    // Random operand pairs with a non-zero divisor.
    for (int i = 0; i < 500; i++) begin
      rx = 16'($urandom_range(0, 65535));
      ry = 8'($urandom_range(1, 255));
      run_div(rx, ry, rx / {8'd0, ry}, 8'(rx % {8'd0, ry}), 1'b0, 16, 17, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
